// File: rtl/exu_muldiv_pkg.sv
// exu_muldiv_pkg: shared types and helpers for the iterative RV32M multiply/divide unit.
//   md_op_e    - operation codes, equal to the RV32M funct3 values
//   md_state_e - unit FSM states
//   XLEN_DEF   - default operand width
//   src1_signed / src2_signed - which operands an op treats as two's complement
package exu_muldiv_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   // MUL follows MULH's sign rule; only its low word is returned, which is
   // identical for signed and unsigned products anyway.
   function automatic logic src1_signed(input md_op_e op);
      return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   function automatic logic src2_signed(input md_op_e op);
      return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/exu_muldiv_if.sv
// exu_muldiv_if: request/result handshake bundle between the issuing stage
// and the multiply/divide unit.
//   i_valid/o_ready/i_op/i_src1/i_src2 - request channel
//   i_flush                            - abort any in-flight op
//   o_valid/i_ready/o_result           - result channel
//   o_busy                             - unit holds an op (BUSY or DONE)
// slave = the unit, master = the requester/consumer.
interface exu_muldiv_if #(
   parameter int XLEN = exu_muldiv_pkg::XLEN_DEF
);
   logic            i_valid;
   logic            o_ready;
   logic [2:0]      i_op;
   logic [XLEN-1:0] i_src1;
   logic [XLEN-1:0] i_src2;
   logic            i_flush;
   logic            o_valid;
   logic            i_ready;
   logic [XLEN-1:0] o_result;
   logic            o_busy;

   modport slave (
      input  i_valid, i_op, i_src1, i_src2, i_flush, i_ready,
      output o_ready, o_valid, o_result, o_busy
   );

   modport master (
      output i_valid, i_op, i_src1, i_src2, i_flush, i_ready,
      input  o_ready, o_valid, o_result, o_busy
   );
endinterface

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV32M multiply/divide unit.
//   i_clk - rising-edge clock
//   i_rst - synchronous active-high reset
//   md    - exu_muldiv_if.slave handshake bundle (request, flush, result, busy)
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// operand magnitudes; the sign is applied once on the finalize edge.
// Normal ops: accept edge, XLEN iteration edges, one finalize edge.
// Divide-by-zero and signed overflow resolve on the accept edge.
module exu_muldiv
   import exu_muldiv_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   exu_muldiv_if.slave md
);

   localparam int CNT_W = $clog2(XLEN) + 1;

   md_state_e         state;
   logic [CNT_W-1:0]  cnt;
   md_op_e            op_q;
   logic              neg_q;
   logic              valid_q;
   logic [XLEN-1:0]   result_q;

   // Shared datapath. Multiply: acc = product, mcand = shifting multiplicand,
   // mplier = shifting multiplier. Divide: acc = {rem, quo}, with the
   // dividend shifted in from the low half; mcand[XLEN-1:0] = divisor.
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplier;

   // ---------------- request decode ----------------
   md_op_e          op_in;
   logic            s1, s2, neg_in;
   logic [XLEN-1:0] mag1, mag2;
   logic            div_zero, div_ovf, ready_c, accept;

   assign op_in   = md_op_e'(md.i_op);
   assign s1      = src1_signed(op_in) & md.i_src1[XLEN-1];
   assign s2      = src2_signed(op_in) & md.i_src2[XLEN-1];
   assign mag1    = s1 ? (~md.i_src1 + 1'b1) : md.i_src1;
   assign mag2    = s2 ? (~md.i_src2 + 1'b1) : md.i_src2;
   // Remainder takes the dividend's sign; everything else the xor.
   assign neg_in  = (op_in == MD_REM) ? s1 : (s1 ^ s2);

   assign div_zero = md.i_op[2] && (md.i_src2 == '0);
   assign div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                     (md.i_src1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (md.i_src2 == '1);

   assign ready_c = (state == ST_IDLE) & ~md.i_flush & ~i_rst;
   assign accept  = md.i_valid & ready_c;

   // ---------------- divide step ----------------
   // Shifted partial remainder needs XLEN+1 bits; one extra bit in the trial
   // acts as the borrow. A restored remainder is always below the divisor,
   // so it fits back into XLEN bits.
   logic [XLEN:0]     rem_sh;
   logic [XLEN+1:0]   trial;
   logic [2*XLEN-1:0] div_next;
   logic              unused_bits;

   assign rem_sh   = acc[2*XLEN-1:XLEN-1];
   assign trial    = {1'b0, rem_sh} - {2'b00, mcand[XLEN-1:0]};
   assign div_next = trial[XLEN+1] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {trial[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
   assign unused_bits = ^{rem_sh[XLEN], trial[XLEN]};

   // ---------------- finalize ----------------
   function automatic logic [2*XLEN-1:0] cneg(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   logic [2*XLEN-1:0] fin_src, fin;
   logic [XLEN-1:0]   fin_word;

   // Divide results are zero-extended before negation; the low word of the
   // 2*XLEN negate equals the XLEN negate.
   assign fin_src  = !op_q[2] ? acc
                   : (op_q[1] ? {{XLEN{1'b0}}, acc[2*XLEN-1:XLEN]}
                              : {{XLEN{1'b0}}, acc[XLEN-1:0]});
   assign fin      = cneg(fin_src, neg_q);
   assign fin_word = (op_q[2] || (op_q == MD_MUL)) ? fin[XLEN-1:0] : fin[2*XLEN-1:XLEN];

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_q     <= MD_MUL;
         neg_q    <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
      end else if (md.i_flush) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q  <= op_in;
                  neg_q <= neg_in;
                  if (div_zero) begin
                     result_q <= md.i_op[1] ? md.i_src1 : '1;
                     valid_q  <= 1'b1;
                     state    <= ST_DONE;
                  end else if (div_ovf) begin
                     result_q <= md.i_op[1] ? '0 : md.i_src1;
                     valid_q  <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     cnt   <= CNT_W'(XLEN);
                     state <= ST_BUSY;
                     if (md.i_op[2]) begin
                        acc   <= {{XLEN{1'b0}}, mag1};
                        mcand <= {{XLEN{1'b0}}, mag2};
                     end else begin
                        acc    <= '0;
                        mcand  <= {{XLEN{1'b0}}, mag1};
                        mplier <= mag2;
                     end
                  end
               end
            end
            ST_BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
                  if (op_q[2]) begin
                     acc <= div_next;
                  end else begin
                     if (mplier[0]) acc <= acc + mcand;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end
               end else begin
                  result_q <= fin_word;
                  valid_q  <= 1'b1;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (md.i_ready) begin
                  valid_q <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign md.o_ready  = ready_c;
   assign md.o_valid  = valid_q;
   assign md.o_result = result_q;
   assign md.o_busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: self-checking bench for exu_muldiv (XLEN=32). Directed
// vectors, randomized ops against an arithmetic reference model,
// backpressure, flush and mid-op reset scenarios.
module tb_exu_muldiv;
   import exu_muldiv_pkg::*;

   localparam int XLEN = 32;
   localparam int NORM_LAT = XLEN + 1;   // edges after the accepting edge

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   exu_muldiv_if #(.XLEN(XLEN)) m();

   exu_muldiv #(.XLEN(XLEN)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .md    (m)
   );

   // Reference model: plain 64-bit integer arithmetic from the RV32M rules.
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint    sa, sb, ua, ub;
      logic [63:0] p;
      logic ovf;
      sa = $signed(a); sb = $signed(b);
      ua = {32'b0, a}; ub = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return '1; if (ovf) return a; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
         3'd6: begin if (b == 0) return a; if (ovf) return '0; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 0;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return NORM_LAT;
   endfunction

   // Issue one op from IDLE, wait for the result, complete the handshake.
   // lat = edges after the accepting edge until o_valid is seen.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!m.o_ready && guard < 100) begin @(negedge clk); guard++; end
      m.i_valid = 1'b1; m.i_op = op; m.i_src1 = a; m.i_src2 = b;
      @(posedge clk); #1;
      m.i_valid = 1'b0;
      lat = 0;
      while (!m.o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      res = m.o_result;
      m.i_ready = 1'b1;
      @(posedge clk); #1;
      m.i_ready = 1'b0;
   endtask

   task automatic test_reset();
      m.i_valid = 0; m.i_op = 0; m.i_src1 = 0; m.i_src2 = 0; m.i_flush = 0; m.i_ready = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (m.o_ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b want 0", m.o_ready); else pass_cnt++;
      @(negedge clk); rst = 1'b0; #1;
      total_cnt++; if (m.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m.o_valid); else pass_cnt++;
      total_cnt++; if (m.o_result !== 32'h0) $display("FAIL reset_result: got %h want 0", m.o_result); else pass_cnt++;
      total_cnt++; if (m.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", m.o_busy); else pass_cnt++;
      total_cnt++; if (m.o_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", m.o_ready); else pass_cnt++;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, exp;
      int          lat;
   } vec_t;

   task automatic test_vectors();
      vec_t v[$];
      logic [31:0] res;
      int lat;
      v.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT});
      v.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORM_LAT});
      v.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM_LAT});
      v.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORM_LAT});
      v.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, NORM_LAT});
      v.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, NORM_LAT});
      v.push_back('{3'd5, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, NORM_LAT});
      v.push_back('{3'd7, 32'hFFFF_FFF9, 32'd2,          32'h0000_0001, NORM_LAT});
      v.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 0});
      v.push_back('{3'd6, 32'd5,          32'd0,          32'h0000_0005, 0});
      v.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
      v.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0});
      foreach (v[i]) begin
         run_op(v[i].op, v[i].a, v[i].b, res, lat);
         total_cnt++; if (res !== v[i].exp) $display("FAIL vec%0d_result op=%0d: got %h want %h", i, v[i].op, res, v[i].exp); else pass_cnt++;
         total_cnt++; if (lat !== v[i].lat) $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, v[i].lat); else pass_cnt++;
         total_cnt++; if (m.o_result !== v[i].exp || m.o_valid !== 1'b0) $display("FAIL vec%0d_idle_hold: got %h/%b want %h/0", i, m.o_result, m.o_valid, v[i].exp); else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res, exp;
      logic [2:0]  op;
      int lat;
      for (int n = 0; n < 60; n++) begin
         op = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = 32'hFFFF_FFFF;
            2: a = 32'($urandom_range(0, 20));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'($urandom_range(1, 20));
            default: b = $urandom;
         endcase
         exp = ref_md(op, a, b);
         run_op(op, a, b, res, lat);
         total_cnt++; if (res !== exp) $display("FAIL rand%0d op=%0d a=%h b=%h: got %h want %h", n, op, a, b, res, exp); else pass_cnt++;
         total_cnt++; if (lat !== ref_lat(op, a, b)) $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, ref_lat(op, a, b)); else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, a2, b2, exp, exp2;
      int lat;
      a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom | 32'h1;
      exp = ref_md(3'd3, a, b); exp2 = ref_md(3'd5, a2, b2);
      @(negedge clk);
      m.i_valid = 1'b1; m.i_op = 3'd3; m.i_src1 = a; m.i_src2 = b;
      @(posedge clk); #1; m.i_valid = 1'b0;
      lat = 0;
      while (!m.o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      total_cnt++; if (lat !== NORM_LAT) $display("FAIL bp_latency: got %0d want %0d", lat, NORM_LAT); else pass_cnt++;
      @(negedge clk);
      m.i_valid = 1'b1; m.i_op = 3'd5; m.i_src1 = a2; m.i_src2 = b2;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         total_cnt++; if (m.o_result !== exp || m.o_valid !== 1'b1) $display("FAIL bp_hold%0d: got %h/%b want %h/1", c, m.o_result, m.o_valid, exp); else pass_cnt++;
         total_cnt++; if (m.o_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", c, m.o_ready); else pass_cnt++;
      end
      @(negedge clk); m.i_ready = 1'b1;
      @(posedge clk); #1; m.i_ready = 1'b0;
      total_cnt++; if (m.o_busy !== 1'b0 || m.o_valid !== 1'b0 || m.o_ready !== 1'b1) $display("FAIL bp_release: got busy=%b valid=%b ready=%b want 0 0 1", m.o_busy, m.o_valid, m.o_ready); else pass_cnt++;
      @(posedge clk); #1; m.i_valid = 1'b0;
      total_cnt++; if (m.o_busy !== 1'b1) $display("FAIL bp_accept: got busy=%b want 1", m.o_busy); else pass_cnt++;
      lat = 0;
      while (!m.o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      total_cnt++; if (m.o_result !== exp2 || lat !== NORM_LAT) $display("FAIL bp_second: got %h lat %0d want %h lat %0d", m.o_result, lat, exp2, NORM_LAT); else pass_cnt++;
      m.i_ready = 1'b1; @(posedge clk); #1; m.i_ready = 1'b0;
   endtask

   // Abort an op on its 10th BUSY cycle via flush or reset.
   task automatic test_abort(input bit use_rst);
      logic [31:0] res;
      int lat, seen;
      string nm;
      nm = use_rst ? "rst" : "flush";
      seen = 0;
      @(negedge clk);
      m.i_valid = 1'b1; m.i_op = 3'd0; m.i_src1 = $urandom | 32'h10; m.i_src2 = $urandom | 32'h10;
      @(posedge clk); #1; m.i_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      if (use_rst) rst = 1'b1; else m.i_flush = 1'b1;
      @(posedge clk); #1;
      total_cnt++; if (m.o_busy !== 1'b0 || m.o_valid !== 1'b0) $display("FAIL %s_idle: got busy=%b valid=%b want 0 0", nm, m.o_busy, m.o_valid); else pass_cnt++;
      if (use_rst) begin
         total_cnt++; if (m.o_result !== 32'h0) $display("FAIL rst_result: got %h want 0", m.o_result); else pass_cnt++;
      end
      rst = 1'b0; m.i_flush = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (m.o_valid) seen++; end
      total_cnt++; if (seen !== 0) $display("FAIL %s_no_valid: got %0d valid cycles want 0", nm, seen); else pass_cnt++;
      run_op(3'd0, 32'd3, 32'd4, res, lat);
      total_cnt++; if (res !== 32'd12 || lat !== NORM_LAT) $display("FAIL %s_after: got %h lat %0d want 0000000c lat %0d", nm, res, lat, NORM_LAT); else pass_cnt++;
   endtask

   task automatic test_flush_corners();
      int lat;
      // flush and a request together in IDLE: flush wins
      @(negedge clk);
      m.i_valid = 1'b1; m.i_flush = 1'b1; m.i_op = 3'd0; m.i_src1 = 32'd5; m.i_src2 = 32'd6;
      #1;
      total_cnt++; if (m.o_ready !== 1'b0) $display("FAIL flush_idle_ready: got %b want 0", m.o_ready); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (m.o_busy !== 1'b0) $display("FAIL flush_idle_accept: got busy=%b want 0", m.o_busy); else pass_cnt++;
      m.i_valid = 1'b0; m.i_flush = 1'b0;
      // flush with i_ready in DONE drops the result
      @(negedge clk);
      m.i_valid = 1'b1; m.i_op = 3'd5; m.i_src1 = 32'd9; m.i_src2 = 32'd0;
      @(posedge clk); #1; m.i_valid = 1'b0;
      lat = 0;
      while (!m.o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      @(negedge clk); m.i_flush = 1'b1; m.i_ready = 1'b1;
      @(posedge clk); #1; m.i_flush = 1'b0; m.i_ready = 1'b0;
      total_cnt++; if (m.o_valid !== 1'b0 || m.o_busy !== 1'b0) $display("FAIL flush_done: got valid=%b busy=%b want 0 0", m.o_valid, m.o_busy); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_backpressure();
      test_flush_corners();
      test_abort(1'b0);
      test_abort(1'b1);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
